// File: rtl/bcd_score_accumulator_pkg.sv
// Shared constants for the BCD score accumulator.
//   - BCD digit width and the largest legal BCD digit
//   - FSM state encoding
//   - clamp applied to the per-hit base points
package bcd_score_accumulator_pkg;

    localparam int          BCD_W         = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0]  POINTS_CLAMP  = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADD    = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [3:0] clamp_points(input logic [3:0] p);
        return (p > POINTS_CLAMP) ? POINTS_CLAMP : p;
    endfunction

endpackage

// File: rtl/bcd_score_accumulator_digit_adder.sv
// Single-digit packed-BCD adder: a + b + cin with decimal (+6) correction.
// Ports:
//   i_a, i_b  BCD digits (0..9)
//   i_cin     carry from the next lower digit
//   o_sum     corrected BCD sum digit
//   o_cout    decimal carry to the next higher digit
module bcd_digit_adder
    import bcd_score_accumulator_pkg::*;
(
    input  logic [BCD_W-1:0] i_a,
    input  logic [BCD_W-1:0] i_b,
    input  logic             i_cin,
    output logic [BCD_W-1:0] o_sum,
    output logic             o_cout
);

    logic [BCD_W:0] w_raw;
    logic [BCD_W:0] w_adj;

    always_comb begin
        w_raw = {1'b0, i_a} + {1'b0, i_b} + {{BCD_W{1'b0}}, i_cin};
        // Anything past 9 wraps into the next decade; +6 skips the six
        // unused binary codes so the low nibble lands on the right digit.
        if (w_raw > {1'b0, BCD_MAX_DIGIT}) begin
            w_adj  = w_raw + (BCD_W+1)'(6);
            o_cout = 1'b1;
        end else begin
            w_adj  = w_raw;
            o_cout = 1'b0;
        end
        o_sum = w_adj[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_score_accumulator.sv
// N-digit packed-BCD score accumulator with hit-streak multiplier.
// A hit latches clamp(points) x multiplier as a 2-digit BCD addend and
// ripples it into a shadow copy of the score one digit per cycle through a
// single shared digit adder; the visible score is replaced only at COMMIT.
// Ports:
//   INPUTCLOCK  system clock (rising edge)
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear, highest priority
//   hit, miss   one-cycle note events
//   points      base points for a hit (binary, clamped to 9)
//   ready       idle, a hit this cycle is accepted
//   score       packed BCD score, digit 0 in [3:0]
//   multiplier  current multiplier 1..MAX_MULT
//   streak      consecutive accepted hits, saturating
//   overflow    sticky, score saturated at all 9s
//   lost_hit    sticky, hit arrived while busy
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a hit, ready=1
// ST_ADD    | adding one BCD digit per cycle into the shadow
// ST_COMMIT | publish shadow (or all 9s on final carry)
module bcd_score_accumulator
    import bcd_score_accumulator_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int COMBO_STEP = 8,
    parameter int MAX_MULT   = 4,
    parameter int STREAK_W   = 8
) (
    input  logic                    INPUTCLOCK,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    hit,
    input  logic                    miss,
    input  logic [3:0]              points,
    output logic                    ready,
    output logic [BCD_W*DIGITS-1:0] score,
    output logic [3:0]              multiplier,
    output logic [STREAK_W-1:0]     streak,
    output logic                    overflow,
    output logic                    lost_hit
);

    localparam int                SW       = BCD_W * DIGITS;
    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [SW-1:0]       r_shadow;
    logic                r_carry;
    logic [BCD_W-1:0]    r_add_lo;
    logic [BCD_W-1:0]    r_add_hi;
    logic [SW-1:0]       r_score;
    logic [STREAK_W-1:0] r_streak;
    logic [3:0]          r_mult;
    logic                r_overflow;
    logic                r_lost;

    logic                w_idle;
    logic                w_accept;
    logic                w_lost;
    logic [STREAK_W-1:0] w_streak_next;
    logic [31:0]         w_q;
    logic [3:0]          w_mult_next;
    logic [3:0]          w_pts;
    logic [7:0]          w_addend;
    logic [BCD_W-1:0]    w_add_lo;
    logic [BCD_W-1:0]    w_add_hi;
    logic [BCD_W-1:0]    w_sh_digit;
    logic [BCD_W-1:0]    w_ad_digit;
    logic [BCD_W-1:0]    w_sum;
    logic                w_cout;

    // A simultaneous miss wins over hit: no points and no lost_hit.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = hit & ~miss & w_idle;
    assign w_lost   = hit & ~miss & ~w_idle;

    always_comb begin
        if (miss)
            w_streak_next = '0;
        else if (w_accept)
            w_streak_next = (&r_streak) ? r_streak : r_streak + STREAK_W'(1);
        else
            w_streak_next = r_streak;
    end

    // Multiplier is derived from the next streak so both update together.
    always_comb begin
        w_q = 32'(w_streak_next) / 32'(COMBO_STEP);
        if (w_q >= 32'(MAX_MULT - 1))
            w_mult_next = 4'(MAX_MULT);
        else
            w_mult_next = 4'(w_q + 32'd1);
    end

    // Addend uses the multiplier as it stood when the hit arrived (<= 81).
    always_comb begin
        w_pts    = clamp_points(points);
        w_addend = 8'(w_pts) * 8'(r_mult);
        w_add_lo = 4'(w_addend % 8'd10);
        w_add_hi = 4'(w_addend / 8'd10);
    end

    always_comb begin
        w_sh_digit = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == IDX_W'(d))
                w_sh_digit = r_shadow[d*BCD_W +: BCD_W];
        end
        if (r_idx == '0)
            w_ad_digit = r_add_lo;
        else if (r_idx == IDX_W'(1))
            w_ad_digit = r_add_hi;
        else
            w_ad_digit = '0;
    end

    bcd_digit_adder u_digit_adder (
        .i_a    (w_sh_digit),
        .i_b    (w_ad_digit),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge INPUTCLOCK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_carry    <= 1'b0;
            r_add_lo   <= '0;
            r_add_hi   <= '0;
            r_score    <= '0;
            r_streak   <= '0;
            r_mult     <= 4'd1;
            r_overflow <= 1'b0;
            r_lost     <= 1'b0;
        end else if (clear) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_carry    <= 1'b0;
            r_add_lo   <= '0;
            r_add_hi   <= '0;
            r_score    <= '0;
            r_streak   <= '0;
            r_mult     <= 4'd1;
            r_overflow <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_streak <= w_streak_next;
            r_mult   <= w_mult_next;
            if (w_lost)
                r_lost <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shadow <= r_score;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_add_lo <= w_add_lo;
                        r_add_hi <= w_add_hi;
                        r_state  <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    for (int d = 0; d < DIGITS; d++) begin
                        if (r_idx == IDX_W'(d))
                            r_shadow[d*BCD_W +: BCD_W] <= w_sum;
                    end
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX)
                        r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // Carry out of the top digit means the score saturates.
                    if (r_carry) begin
                        r_score    <= {DIGITS{BCD_MAX_DIGIT}};
                        r_overflow <= 1'b1;
                    end else begin
                        r_score <= r_shadow;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready      = w_idle;
    assign score      = r_score;
    assign multiplier = r_mult;
    assign streak     = r_streak;
    assign overflow   = r_overflow;
    assign lost_hit   = r_lost;

endmodule
